// File: rtl/spart_driver_if.sv
// Processor-side bus between spart_driver (master) and the SPART bus interface (slave).
// databus is resolved here: the master drives it only on a write cycle, the slave
// only when it asserts rd_en, otherwise it floats.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] dout;
  logic       rda;
  logic       tbr;
  logic [7:0] rd_data;
  logic       rd_en;
  wire  [7:0] databus;

  // Single resolution point for the shared bus; Z whenever nobody owns it.
  assign databus = (iocs && !iorw) ? dout : (rd_en ? rd_data : 8'hzz);

  modport master (
    output iocs, iorw, ioaddr, dout,
    input  rda, tbr, databus
  );

  modport slave (
    input  iocs, iorw, ioaddr, databus,
    output rda, tbr, rd_data, rd_en
  );
endinterface

// File: rtl/spart_driver.sv
// CPU stand-in for the SPART minilab: programs the baud divisor from br_cfg,
// then echoes every received byte back to the transmitter (polled rda/tbr).
//
// state    | meaning
// ---------+------------------------------------------------------------
// CFG_LO   | write divisor low byte (ioaddr 10), latch cfg_cur
// CFG_HI   | write divisor high byte (ioaddr 11), raise cfg_done
// IDLE     | no bus cycle; reprogram on br_cfg change, else wait for rda
// RD       | read rx buffer (ioaddr 00)
// WAIT_TBR | no bus cycle; wait for transmit buffer ready
// WR       | write held byte to tx buffer, bump echo_cnt
//
// Outputs are registered from the state being left, so each state's bus cycle
// is the clock period that follows the edge at which that state is processed.
module spart_driver #(
  parameter int CLK_HZ = 50_000_000,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       br_cfg,
  spart_driver_if.master   bus,
  output logic             cfg_done,
  output logic [CNT_W-1:0] echo_cnt
);

  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    IDLE     = 3'd2,
    RD       = 3'd3,
    WAIT_TBR = 3'd4,
    WR       = 3'd5
  } state_t;

  localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (16 * 4800) - 1);
  localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (16 * 9600) - 1);
  localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (16 * 19200) - 1);
  localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (16 * 38400) - 1);

  function automatic logic [7:0] div_byte(input logic [1:0] sel, input logic hi);
    logic [15:0] d;
    case (sel)
      2'b00:   d = DIV_4800;
      2'b01:   d = DIV_9600;
      2'b10:   d = DIV_19200;
      default: d = DIV_38400;
    endcase
    return hi ? d[15:8] : d[7:0];
  endfunction

  state_t     state, state_nxt;
  logic [1:0] br_meta, br_sync, cfg_cur;
  logic [7:0] rx_byte;
  logic       iocs_nxt, iorw_nxt, cfg_done_nxt, latch_cfg, echo_inc;
  logic [1:0] ioaddr_nxt;
  logic [7:0] dout_nxt;

  // Two-flop synchroniser for the asynchronous baud switches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_meta <= 2'b00;
      br_sync <= 2'b00;
    end else begin
      br_meta <= br_cfg;
      br_sync <= br_meta;
    end
  end

  // Next state plus the bus cycle and side effects of the state being left.
  always_comb begin
    state_nxt    = state;
    iocs_nxt     = 1'b0;
    iorw_nxt     = 1'b1;
    ioaddr_nxt   = 2'b00;
    dout_nxt     = 8'h00;
    cfg_done_nxt = cfg_done;
    latch_cfg    = 1'b0;
    echo_inc     = 1'b0;
    case (state)
      CFG_LO: begin
        iocs_nxt   = 1'b1;
        iorw_nxt   = 1'b0;
        ioaddr_nxt = 2'b10;
        dout_nxt   = div_byte(br_sync, 1'b0);
        latch_cfg  = 1'b1;
        state_nxt  = CFG_HI;
      end
      CFG_HI: begin
        iocs_nxt     = 1'b1;
        iorw_nxt     = 1'b0;
        ioaddr_nxt   = 2'b11;
        dout_nxt     = div_byte(cfg_cur, 1'b1);
        cfg_done_nxt = 1'b1;
        state_nxt    = IDLE;
      end
      IDLE: begin
        if (br_sync != cfg_cur) begin
          cfg_done_nxt = 1'b0;
          state_nxt    = CFG_LO;
        end else if (bus.rda) begin
          state_nxt = RD;
        end
      end
      RD: begin
        iocs_nxt  = 1'b1;
        state_nxt = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (bus.tbr) state_nxt = WR;
      end
      WR: begin
        iocs_nxt  = 1'b1;
        iorw_nxt  = 1'b0;
        dout_nxt  = rx_byte;
        echo_inc  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = CFG_LO;
    endcase
  end

  // State register; reset restarts configuration from the low byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CFG_LO;
    else     state <= state_nxt;
  end

  // Registered bus outputs; async reset drops iocs so databus floats at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.iocs   <= 1'b0;
      bus.iorw   <= 1'b1;
      bus.ioaddr <= 2'b00;
      bus.dout   <= 8'h00;
      cfg_done   <= 1'b0;
    end else begin
      bus.iocs   <= iocs_nxt;
      bus.iorw   <= iorw_nxt;
      bus.ioaddr <= ioaddr_nxt;
      bus.dout   <= dout_nxt;
      cfg_done   <= cfg_done_nxt;
    end
  end

  // Remember which baud select the low byte was computed from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            cfg_cur <= 2'b00;
    else if (latch_cfg) cfg_cur <= br_sync;
  end

  // Capture the received byte at the end of the read bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             rx_byte <= 8'h00;
    else if (bus.iocs && bus.iorw && bus.ioaddr == 2'b00) rx_byte <= bus.databus;
  end

  // Echo counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           echo_cnt <= '0;
    else if (echo_inc) echo_cnt <= echo_cnt + 1'b1;
  end

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: a SPART slave model on the bus, a monitor that logs
// every bus cycle, and a reference model of divisors and echoed bytes.
module tb_spart_driver;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [1:0]       br_cfg;
  logic             cfg_done;
  logic [CNT_W-1:0] echo_cnt;
  logic [7:0]       rx_tb;

  spart_driver_if bus();

  assign bus.rd_en   = bus.iocs && bus.iorw;
  assign bus.rd_data = rx_tb;

  spart_driver #(.CLK_HZ(50_000_000), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus),
    .cfg_done (cfg_done),
    .echo_cnt (echo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int rd_cyc   = 0;
  int wr_cyc   = 0;
  int lo_cyc   = 0;
  int exp_echo = 0;
  logic [7:0] wr_q[$];
  logic [8:0] cfg_q[$];
  logic       prev_iocs = 1'b0;
  logic       prev_iorw = 1'b1;
  logic [1:0] prev_addr = 2'b00;

  // Divisor from the baud table: CLK_HZ / (16 * baud) - 1.
  function automatic int ref_div(input int sel);
    int baud;
    baud = 4800 * (1 << sel);
    return 50_000_000 / (16 * baud) - 1;
  endfunction

  function automatic logic [17:0] ref_pair(input int sel);
    int d;
    d = ref_div(sel);
    return {1'b0, 8'(d), 1'b1, 8'(d >> 8)};
  endfunction

  function automatic logic [17:0] last_pair();
    int n;
    n = cfg_q.size();
    if (n < 2) return 18'h0;
    return {cfg_q[n-2], cfg_q[n-1]};
  endfunction

  // Bus monitor: logs cycles mid-period and flags back-to-back chip selects.
  always @(negedge clk) begin
    cyc++;
    if (bus.iocs && bus.iorw) begin
      rd_cnt++;
      rd_cyc = cyc;
    end
    if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
      wr_q.push_back(bus.databus);
      wr_cyc = cyc;
    end
    if (bus.iocs && !bus.iorw && bus.ioaddr[1]) begin
      cfg_q.push_back({bus.ioaddr[0], bus.databus});
      if (!bus.ioaddr[0]) lo_cyc = cyc;
    end
    if (prev_iocs && bus.iocs) begin
      checks++;
      if (!(prev_addr == 2'b10 && bus.ioaddr == 2'b11 && !prev_iorw && !bus.iorw)) begin
        errors++;
        $display("FAIL back_to_back_iocs: got addr %0d->%0d iorw %0d->%0d, required only 2->3 writes",
                 prev_addr, bus.ioaddr, prev_iorw, bus.iorw);
      end
    end
    prev_iocs = bus.iocs;
    prev_iorw = bus.iorw;
    prev_addr = bus.ioaddr;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_read(input int n0, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (rd_cnt != n0) ok = 1'b1;
    end
  endtask

  task automatic wait_wr(input int w0, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (wr_q.size() != w0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; br_cfg = 2'b01; bus.rda = 1'b0; bus.tbr = 1'b0; rx_tb = 8'h00;
    repeat (3) tick();
    checks++;
    if ({bus.iocs, bus.iorw, bus.ioaddr} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_bus: got iocs/iorw/addr=%b, required 0100", {bus.iocs, bus.iorw, bus.ioaddr});
    end
    checks++;
    if (cfg_done !== 1'b0 || echo_cnt !== '0) begin
      errors++;
      $display("FAIL reset_regs: got cfg_done=%b echo_cnt=%0d, required 0/0", cfg_done, echo_cnt);
    end
    rst = 1'b0;
    cfg_q.delete(); wr_q.delete(); exp_echo = 0;
    repeat (12) tick();
    checks++;
    if (cfg_q.size() != 4 || {cfg_q[0], cfg_q[1]} !== ref_pair(0)) begin
      errors++;
      $display("FAIL reset_first_cfg: got %0d writes, first pair %h, required 4 writes first pair %h",
               cfg_q.size(), {cfg_q[0], cfg_q[1]}, ref_pair(0));
    end
    checks++;
    if (last_pair() !== ref_pair(1) || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL reset_cfg_9600: got pair %h done=%b, required %h done=1", last_pair(), cfg_done, ref_pair(1));
    end
  endtask

  task automatic echo_one(input logic [7:0] b, input int hold, input string name);
    int   n0, w0, busy;
    logic ok;
    bus.tbr = (hold == 0);
    rx_tb   = b;
    n0      = rd_cnt;
    w0      = wr_q.size();
    bus.rda = 1'b1;
    wait_read(n0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_read: got no read cycle, required one", name);
    end
    @(posedge clk); #1;
    bus.rda = 1'b0;
    busy = 0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus.iocs) busy++;
    end
    if (hold > 0) begin
      checks++;
      if (busy != 0 || wr_q.size() != w0) begin
        errors++;
        $display("FAIL %s_hold: got %0d iocs cycles while tbr low, required 0", name, busy);
      end
    end
    bus.tbr = 1'b1;
    wait_wr(w0, ok);
    exp_echo++;
    checks++;
    if (!ok || wr_q[w0] !== b) begin
      errors++;
      $display("FAIL %s_data: got %h, required %h", name, ok ? wr_q[w0] : 8'h00, b);
    end
    checks++;
    if (echo_cnt !== CNT_W'(exp_echo)) begin
      errors++;
      $display("FAIL %s_cnt: got %0d, required %0d", name, echo_cnt, CNT_W'(exp_echo));
    end
    if (hold == 0) begin
      checks++;
      if (wr_cyc - rd_cyc != 2) begin
        errors++;
        $display("FAIL %s_latency: got %0d cycles read->write, required 2", name, wr_cyc - rd_cyc);
      end
    end
    repeat (3) tick();
    checks++;
    if (wr_q.size() != w0 + 1) begin
      errors++;
      $display("FAIL %s_single: got %0d writes, required 1", name, wr_q.size() - w0);
    end
  endtask

  task automatic test_echo();
    echo_one(8'h41, 0, "echo_41");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      echo_one(8'($urandom), int'($urandom_range(0, 4)), "random");
  endtask

  task automatic test_wait_tbr();
    echo_one(8'($urandom), 20, "wait_tbr");
  endtask

  task automatic test_reconfig();
    int         c0, c1, n0, w0;
    logic       ok;
    logic [7:0] b;
    c0 = cfg_q.size();
    br_cfg = 2'b11;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (cfg_q.size() > c0) ok = 1'b1;
    end
    checks++;
    if (!ok || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL reconfig_start: got lo_seen=%b cfg_done=%b, required 1/0", ok, cfg_done);
    end
    repeat (6) tick();
    checks++;
    if (cfg_q.size() != c0 + 2 || last_pair() !== ref_pair(3) || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_38400: got %0d writes pair %h done=%b, required 2 writes %h done=1",
               cfg_q.size() - c0, last_pair(), cfg_done, ref_pair(3));
    end
    b = 8'($urandom);
    bus.tbr = 1'b0; rx_tb = b; n0 = rd_cnt; w0 = wr_q.size();
    bus.rda = 1'b1;
    wait_read(n0, ok);
    @(posedge clk); #1;
    bus.rda = 1'b0;
    br_cfg  = 2'b01;
    c1 = cfg_q.size();
    repeat (8) tick();
    checks++;
    if (!ok || cfg_q.size() != c1 || cfg_done !== 1'b1) begin
      errors++;
      $display("FAIL deferred_cfg: got read=%b %0d cfg writes done=%b, required 1/0/1", ok, cfg_q.size() - c1, cfg_done);
    end
    bus.tbr = 1'b1;
    wait_wr(w0, ok);
    exp_echo++;
    checks++;
    if (!ok || wr_q[w0] !== b) begin
      errors++;
      $display("FAIL deferred_data: got %h, required %h", ok ? wr_q[w0] : 8'h00, b);
    end
    repeat (10) tick();
    checks++;
    if (cfg_q.size() != c1 + 2 || last_pair() !== ref_pair(1) || lo_cyc <= wr_cyc) begin
      errors++;
      $display("FAIL deferred_apply: got %0d writes pair %h lo@%0d wr@%0d, required 2 writes %h after write",
               cfg_q.size() - c1, last_pair(), lo_cyc, wr_cyc, ref_pair(1));
    end
  endtask

  task automatic test_reset_mid_wr();
    int   n0, w0, c0;
    logic ok;
    bus.tbr = 1'b0; rx_tb = 8'h5A; n0 = rd_cnt; w0 = wr_q.size();
    bus.rda = 1'b1;
    wait_read(n0, ok);
    @(posedge clk); #1;
    bus.rda = 1'b0;
    repeat (3) tick();
    bus.tbr = 1'b1;
    wait_wr(w0, ok);
    rst = 1'b1;
    #1;
    checks++;
    if (!ok || bus.iocs !== 1'b0 || bus.iorw !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_wr_bus: got wr_seen=%b iocs=%b iorw=%b, required 1/0/1", ok, bus.iocs, bus.iorw);
    end
    checks++;
    if (echo_cnt !== '0 || cfg_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wr_regs: got echo_cnt=%0d cfg_done=%b, required 0/0", echo_cnt, cfg_done);
    end
    exp_echo = 0;
    repeat (2) tick();
    c0 = cfg_q.size();
    rst = 1'b0;
    repeat (12) tick();
    checks++;
    if (cfg_q.size() != c0 + 4 || last_pair() !== ref_pair(1) || cfg_done !== 1'b1 || echo_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_wr_recfg: got %0d writes pair %h done=%b cnt=%0d, required 4 writes %h done=1 cnt=0",
               cfg_q.size() - c0, last_pair(), cfg_done, echo_cnt, ref_pair(1));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         n0, w0, mism;
    logic       ok;
    bus.tbr = 1'b1;
    w0 = wr_q.size();
    bus.rda = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      rx_tb = b;
      n0 = rd_cnt;
      wait_read(n0, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_read: got no read for echo %0d, required one", i);
        break;
      end
      @(posedge clk); #1;
    end
    bus.rda = 1'b0;
    repeat (10) tick();
    checks++;
    if (wr_q.size() != w0 + 256) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes, required 256", wr_q.size() - w0);
    end
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (w0 + i >= wr_q.size() || wr_q[w0 + i] !== exp_q[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL b2b_order: got %0d mismatched bytes, required 0", mism);
    end
    exp_echo += 256;
    checks++;
    if (echo_cnt !== CNT_W'(exp_echo)) begin
      errors++;
      $display("FAIL b2b_wrap: got echo_cnt=%0d, required %0d", echo_cnt, CNT_W'(exp_echo));
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_random();
    test_wait_tbr();
    test_reconfig();
    test_reset_mid_wr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
